// File: rtl/mandelbrot_scanout.sv
// mandelbrot_scanout
//   Raster scan-out engine for a Mandelbrot framebuffer. Generates VGA-style
//   timing, fetches one framebuffer word per active pixel and maps iteration
//   values through an 8-entry, writable, colour-cycling RGB 4:4:4 palette.
//
// Ports
//   clk          pixel clock, also clocks the framebuffer read port
//   reset        synchronous, active-low
//   display_en   show framebuffer contents (sampled at frame boundaries)
//   cycle_en     enable palette colour cycling
//   cycle_div    frames per colour-cycle step, minus 1
//   pal_we/pal_addr/pal_data   palette write port
//   read_en/read_addr          framebuffer read request
//   read_data    framebuffer word, valid one cycle after read_en
//   hsync/vsync  active-low sync pulses
//   de/rgb       active video flag and pixel colour
//   frame_start  one-cycle pulse with the first active pixel of a frame
module mandelbrot_scanout #(
  parameter int width     = 1024,
  parameter int height    = 768,
  parameter int h_front   = 24,
  parameter int h_sync    = 136,
  parameter int h_back    = 160,
  parameter int v_front   = 3,
  parameter int v_sync    = 6,
  parameter int v_back    = 29,
  parameter int data_bits = 4,
  localparam int dimension_bits = $clog2(width - 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          display_en,
  input  logic                          cycle_en,
  input  logic [3:0]                    cycle_div,
  input  logic                          pal_we,
  input  logic [2:0]                    pal_addr,
  input  logic [11:0]                   pal_data,
  output logic                          read_en,
  output logic [dimension_bits*2-1:0]   read_addr,
  input  logic [data_bits-1:0]          read_data,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [11:0]                   rgb,
  output logic                          frame_start
);

  localparam int h_total   = width + h_front + h_sync + h_back;
  localparam int v_total   = height + v_front + v_sync + v_back;
  localparam int hc_bits   = $clog2(h_total);
  localparam int vc_bits   = $clog2(v_total);
  localparam int addr_bits = dimension_bits * 2;

  localparam logic [hc_bits-1:0] h_last = hc_bits'(h_total - 1);
  localparam logic [hc_bits-1:0] h_act  = hc_bits'(width);
  localparam logic [hc_bits-1:0] hs_on  = hc_bits'(width + h_front);
  localparam logic [hc_bits-1:0] hs_off = hc_bits'(width + h_front + h_sync);
  localparam logic [vc_bits-1:0] v_last = vc_bits'(v_total - 1);
  localparam logic [vc_bits-1:0] v_act  = vc_bits'(height);
  localparam logic [vc_bits-1:0] vs_on  = vc_bits'(height + v_front);
  localparam logic [vc_bits-1:0] vs_off = vc_bits'(height + v_front + v_sync);

  localparam logic [11:0] pal_init [8] = '{
    12'h00F, 12'h03F, 12'h0AF, 12'h0FA, 12'h4F0, 12'hFF0, 12'hF80, 12'hF00
  };

  typedef enum logic {BLANK, SHOW} state_t;

  state_t               state;
  logic [hc_bits-1:0]   hcount;
  logic [vc_bits-1:0]   vcount;
  logic [addr_bits-1:0] addr_cnt;
  logic [2:0]           offset;
  logic [3:0]           fcnt;
  logic [11:0]          palette [8];

  logic active0, hs0, vs0, boundary;
  logic de1, hs1, vs1, fs1;
  logic de2, hs2, vs2, fs2;
  logic [2:0]  pal_idx;
  logic [11:0] colour;

  // Counter stage
  always_comb begin
    active0  = (hcount < h_act) && (vcount < v_act);
    hs0      = !((hcount >= hs_on) && (hcount < hs_off));
    vs0      = !((vcount >= vs_on) && (vcount < vs_off));
    boundary = (hcount == '0) && (vcount == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == h_last) begin
      hcount <= '0;
      vcount <= (vcount == v_last) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Linear framebuffer address built by counting active pixels; it is
  // cleared on the final counter position of the frame so that (0,0) reads 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_cnt <= '0;
    end else if ((hcount == h_last) && (vcount == v_last)) begin
      addr_cnt <= '0;
    end else if (active0) begin
      addr_cnt <= addr_cnt + 1'b1;
    end
  end

  // Display FSM and colour-cycle counter, both stepped at the frame boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= BLANK;
      offset <= '0;
      fcnt   <= '0;
    end else begin
      if (boundary) begin
        case (state)
          BLANK:   if (display_en)  state <= SHOW;
          SHOW:    if (!display_en) state <= BLANK;
          default: state <= BLANK;
        endcase
      end
      if (!cycle_en) begin
        fcnt <= '0;
      end else if (boundary) begin
        if (fcnt == cycle_div) begin
          fcnt   <= '0;
          offset <= offset + 1'b1;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Palette: writes land on the next edge, so a same-cycle lookup sees the old entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) palette[i] <= pal_init[i];
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // Stage 1: framebuffer request plus timing flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_en   <= 1'b0;
      read_addr <= '0;
      de1       <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      fs1       <= 1'b0;
    end else begin
      read_en   <= active0;
      read_addr <= addr_cnt;
      de1       <= active0;
      hs1       <= hs0;
      vs1       <= vs0;
      fs1       <= boundary;
    end
  end

  // Stage 2: timing flags wait alongside the framebuffer latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      de2 <= 1'b0;
      hs2 <= 1'b1;
      vs2 <= 1'b1;
      fs2 <= 1'b0;
    end else begin
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      fs2 <= fs1;
    end
  end

  // Values 0 (unrendered) and 1 (inside the set) are black
  always_comb begin
    pal_idx = read_data[3:1] + offset;
    colour  = '0;
    if (de2 && (state == SHOW) && (read_data[data_bits-1:1] != '0))
      colour = palette[pal_idx];
  end

  // Stage 3: registered, mutually aligned outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else begin
      de          <= de2;
      hsync       <= hs2;
      vsync       <= vs2;
      frame_start <= fs2;
      rgb         <= colour;
    end
  end

endmodule

// File: tb/tb_mandelbrot_scanout.sv
// Self-checking bench for mandelbrot_scanout using a shrunken raster
// (16x8 active, 24x13 total) so that many frames fit in a short run.
module tb_mandelbrot_scanout;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DB = $clog2(W - 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic display_en = 1'b0;
  logic cycle_en = 1'b0;
  logic [3:0] cycle_div = '0;
  logic pal_we = 1'b0;
  logic [2:0] pal_addr = '0;
  logic [11:0] pal_data = '0;
  logic read_en;
  logic [DB*2-1:0] read_addr;
  logic [3:0] read_data = '0;
  logic hsync, vsync, de, frame_start;
  logic [11:0] rgb;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [3:0]  fb [256];
  logic [11:0] pal_rst [8] = '{12'h00F, 12'h03F, 12'h0AF, 12'h0FA,
                               12'h4F0, 12'hFF0, 12'hF80, 12'hF00};

  always #5 clk = ~clk;

  mandelbrot_scanout #(
    .width(W), .height(H),
    .h_front(HF), .h_sync(HS), .h_back(HB),
    .v_front(VF), .v_sync(VS), .v_back(VB),
    .data_bits(4)
  ) dut (
    .clk(clk), .reset(reset), .display_en(display_en), .cycle_en(cycle_en),
    .cycle_div(cycle_div), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  // Framebuffer with one cycle of read latency
  always @(posedge clk) if (read_en) read_data <= fb[read_addr];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel p of the raster is presented at the counter stage
  // on the p-th cycle after reset; its request appears one edge later and its
  // outputs three edges later.
  int unsigned n = 0;
  bit          m_show = 1'b0;
  int unsigned m_off = 0;
  int unsigned m_fcnt = 0;
  logic [11:0] m_pal [8];

  always @(posedge clk) begin : model
    logic r, den, cen, we;
    logic [3:0] cdv;
    logic [2:0] pa;
    logic [11:0] pd;
    int unsigned p, q, h, v, d;
    bit e_de;
    logic [11:0] e_rgb;
    r = reset; den = display_en; cen = cycle_en; we = pal_we;
    cdv = cycle_div; pa = pal_addr; pd = pal_data;
    #1;
    if (!r) begin
      n = 0; m_show = 1'b0; m_off = 0; m_fcnt = 0;
      for (int i = 0; i < 8; i++) m_pal[i] = pal_rst[i];
      chk("read_en_rst", read_en, 0);
      chk("read_addr_rst", read_addr, 0);
      chk("de_rst", de, 0);
      chk("rgb_rst", rgb, 0);
      chk("hsync_rst", hsync, 1);
      chk("vsync_rst", vsync, 1);
      chk("frame_start_rst", frame_start, 0);
    end else begin
      n++;
      p = n - 1;
      if (p % FRAME == 0) begin
        m_show = den;
        if (cen) begin
          if (m_fcnt == cdv) begin
            m_fcnt = 0;
            m_off = (m_off + 1) % 8;
          end else begin
            m_fcnt = (m_fcnt + 1) % 16;
          end
        end
      end
      if (!cen) m_fcnt = 0;
      h = p % HT; v = (p / HT) % VT;
      chk("read_en", read_en, (h < W && v < H));
      if (h < W && v < H) chk("read_addr", read_addr, v * W + h);
      if (n >= 3) begin
        q = n - 3; h = q % HT; v = (q / HT) % VT;
        e_de = (h < W && v < H);
        e_rgb = '0;
        if (e_de && m_show) begin
          d = fb[v * W + h];
          if (d >= 2) e_rgb = m_pal[((d >> 1) + m_off) % 8];
        end
        chk("de", de, e_de);
        chk("rgb", rgb, e_rgb);
        chk("hsync", hsync, !(h >= W + HF && h < W + HF + HS));
        chk("vsync", vsync, !(v >= H + VF && v < H + VF + VS));
        chk("frame_start", frame_start, (h == 0 && v == 0));
      end else begin
        chk("de_fill", de, 0);
        chk("rgb_fill", rgb, 0);
        chk("hsync_fill", hsync, 1);
        chk("vsync_fill", vsync, 1);
        chk("frame_start_fill", frame_start, 0);
      end
    end
    if (r && we) m_pal[pa] = pd;
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_start_wait", ok, 1);
  endtask

  initial begin
    int unsigned c_de, c_hs, c_vs, c_rgb;
    bit seen;
    for (int i = 0; i < 256; i++) fb[i] = 4'($urandom_range(0, 15));
    fb[0] = 4'd2; fb[1] = 4'd5; fb[2] = 4'd15; fb[3] = 4'd0; fb[4] = 4'd1; fb[5] = 4'd6;

    // Reset, then two blank frames of timing
    step(5);
    reset = 1'b1;
    step(10);
    c_de = 0; c_hs = 0; c_vs = 0; c_rgb = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      c_de  += (de == 1'b1);
      c_hs  += (hsync == 1'b0);
      c_vs  += (vsync == 1'b0);
      c_rgb += (rgb != 12'h000);
    end
    chk("de_count_2fr", c_de, 256);
    chk("hsync_low_2fr", c_hs, 78);
    chk("vsync_low_2fr", c_vs, 96);
    chk("rgb_nonzero_blank", c_rgb, 0);

    // Enable display mid-frame; the following frame shows data
    wait_fs();
    step(50);
    display_en = 1'b1;
    wait_fs();
    chk("fs_with_de", de, 1);
    chk("rgb_d2", rgb, 12'h03F);
    step(1); chk("rgb_d5", rgb, 12'h0AF);
    step(1); chk("rgb_d15", rgb, 12'hF00);
    step(1); chk("rgb_d0", rgb, 12'h000);
    step(1); chk("rgb_d1", rgb, 12'h000);

    // Colour cycling every 2 frames
    cycle_en = 1'b1;
    cycle_div = 4'd1;
    for (int k = 1; k <= 16; k++) begin
      wait_fs();
      if (k == 2)  chk("cycle_off1", rgb, 12'h0AF);
      if (k == 4)  chk("cycle_off2", rgb, 12'h0FA);
      if (k == 16) chk("cycle_wrap", rgb, 12'h03F);
    end
    cycle_en = 1'b0;

    // Palette write during active video
    step(2);
    pal_we = 1'b1; pal_addr = 3'd3; pal_data = 12'hABC;
    step(1);
    pal_we = 1'b0;
    wait_fs();
    chk("pal_other_entry", rgb, 12'h03F);
    step(5);
    chk("pal_written", rgb, 12'hABC);

    // Randomised control and palette traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) display_en = ~display_en;
      if ($urandom_range(0, 299) == 0) begin
        cycle_en = ~cycle_en;
        cycle_div = 4'($urandom_range(0, 3));
      end
      pal_we = ($urandom_range(0, 31) == 0);
      pal_addr = 3'($urandom_range(0, 7));
      pal_data = 12'($urandom_range(0, 4095));
    end
    pal_we = 1'b0;

    // One-cycle reset in the middle of the active area (pixel 10, line 5)
    wait_fs();
    step(5 * HT + 10 - 3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (read_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("read_en_after_reset", seen, 1);
    chk("read_addr_after_reset", read_addr, 0);
    step(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
